esm_issue_window: RTL and testbench
===================================

Name: esm_issue_window

Overview:
- Parametrised successor to the ESM instruction buffer/issuer.
- Fills an instruction window of DEPTH entries through a valid/ready handshake, then drains it with one issue per cycle.
- In OOO mode, the oldest entry that is free of hazards against older unissued entries and against a register busy scoreboard is issued first. Writeback clears scoreboard bits. In in-order mode, issue is strictly in age order.
- Sits between fetch and the execute/regfile stage.

Parameters:
- INSTR_W, 32, instruction width; must be >= 25. Fields are rd=[11:7], rs1=[19:15], rs2=[24:20].
- DEPTH, 16, window entries; power of two, >= 2.
- REGNUM, 32, architectural registers. REG_W=$clog2(REGNUM) is a localparam, and REG_W <= 5.
- OOO, 1, 1 = hazard-aware out-of-order issue; 0 = strict in-order issue.
- DRAIN_ON_IDLE, 1, 1 = start drain when in_valid is low and count>0; 0 = drain only when the window is full or in_last is seen.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input instruction valid.
- in_ready  out  1  window can accept (state FILL and count<DEPTH).
- in_instr  in  INSTR_W  instruction word.
- in_regwrite  in  1  instruction writes rd.
- in_alusrc  in  1  1 = immediate operand, so rs2 is unused.
- in_last  in  1  last instruction of the batch; qualified by the in_valid&&in_ready handshake.
- out_valid  out  1  an issuable entry is presented.
- out_ready  in  1  downstream accepts the issue.
- out_instr  out  INSTR_W  issued instruction.
- out_idx  out  $clog2(DEPTH)  window slot of the issued entry.
- wb_valid  in  1  writeback event.
- wb_rd  in  REG_W  register being written back; clears its busy bit.
- busy_q  out  REGNUM  scoreboard, for debug.
- drain_done  out  1  one-cycle pulse when the last entry issues.

Behaviour:
- Reset (clk edge with rst=1): state=FILL, count=0, all entry valid/issued bits cleared, busy_q=0, out_valid=0, in_ready=1, drain_done=0.
- Reset mid-drain discards all entries.
- States are FILL and DRAIN.
- FILL:
  - On in_valid&&in_ready: write slot[count] with instr, regwrite, rs2_used=~alusrc; then count++.
  - Go to DRAIN at the next edge if any of these holds:
    - the accepted instruction makes count==DEPTH;
    - in_last is accepted;
    - DRAIN_ON_IDLE=1, in_valid==0 and count>0.
  - out_valid=0 throughout FILL.
- DRAIN:
  - in_ready=0.
  - Eligible entry: valid, not issued, and satisfies all of:
    - no source (rs1; rs2 if used) busy in busy_q;
    - if regwrite, rd not busy;
    - (OOO=1) no RAW, WAR or WAW hazard against any lower-index unissued entry.
    - Register 0 never creates a hazard and is never marked busy.
  - Selection when OOO=1: lowest-index eligible entry.
  - Selection when OOO=0: only the lowest-index unissued entry is a candidate, and it is subject to the busy checks.
  - out_valid/out_instr/out_idx are combinational from registered state. An entry is presented in the first DRAIN cycle, with no extra latency.
  - On out_valid&&out_ready: mark the entry issued; if it has regwrite and rd!=0, set busy[rd].
  - If out_valid is low, downstream waits. out_valid may change between cycles as writebacks arrive; downstream must not assume stability without a handshake.
  - When the final unissued entry issues: pulse drain_done, clear all entries, set count=0, and return to FILL at the next edge.
- Scoreboard:
  - wb_valid clears busy[wb_rd] at the edge and is effective for selection from the next cycle.
  - If an issue sets and a writeback clears the same register in the same cycle, the set wins.
  - wb_rd=0 or wb_rd>=REGNUM is ignored.
  - The scoreboard persists across batches and is cleared only by rst.
  - A register that never receives a writeback stalls dependents indefinitely. This is legal, and no timeout is provided.
- Simultaneous events: the accept in the last FILL cycle and the transition to DRAIN happen at the same edge.

Decomposition:
- Package esm_pkg holds:
  - the state enum (FILL, DRAIN);
  - RD_LSB=7, RS1_LSB=15, RS2_LSB=20 and FIELD_W=5;
  - the entry struct {instr, regwrite, rs2_used, valid, issued};
  - function hazard(older, younger), returning the RAW/WAR/WAW result.
- Sub-module esm_scoreboard (REGNUM): busy set/clear with set priority, plus the busy_q output.
- The window, selector and FSM stay in the top module.

Test Plan:
- Reset, then 3 independent instructions (rd=1,2,3; rs=0) with in_last on the third → DRAIN after 3 accepts; out_idx 0,1,2 on consecutive cycles with out_ready=1; drain_done on the 3rd issue; busy_q=0b1110.
- OOO=1, busy_q preset with r5 busy (issue, no wb): window [add r6,r5,r0; add r7,r1,r2] → slot1 issues first; slot0 issues the cycle after wb_rd=5.
- OOO=0, same stimulus → nothing issues until wb_rd=5; then slot0 then slot1, in order.
- Fill 16 entries without in_last → in_ready drops after the 16th accept; the 17th in_valid is held off; DRAIN is entered.
- WAR/WAW: [add r1,r2,r0; add r2,r3,r0; add r1,r4,r0] with all regs free, OOO=1 → issue order 0,1,2 (slot1 waits for slot0, slot2 waits for slot0 via WAW); r1 and r2 end busy.
- Assert rst mid-drain after 1 of 4 issues → next cycle: state FILL, out_valid=0, busy_q=0, in_ready=1.

Source files
------------

// File: rtl/esm_pkg.sv
// Shared types and helpers for the ESM issue window: FSM states, instruction
// field positions, the window entry record and the pairwise hazard check.
package esm_pkg;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  localparam int RD_LSB      = 7;
  localparam int RS1_LSB     = 15;
  localparam int RS2_LSB     = 20;
  localparam int FIELD_W     = 5;
  // Storage width of the instruction field in an entry; the window's INSTR_W
  // must not exceed it. Unused upper bits stay zero.
  localparam int MAX_INSTR_W = 64;

  typedef struct packed {
    logic [MAX_INSTR_W-1:0] instr;
    logic                   regwrite;
    logic                   rs2_used;
    logic                   valid;
    logic                   issued;
  } entry_t;

  function automatic logic [FIELD_W-1:0] f_rd(input entry_t e);
    return e.instr[RD_LSB +: FIELD_W];
  endfunction

  function automatic logic [FIELD_W-1:0] f_rs1(input entry_t e);
    return e.instr[RS1_LSB +: FIELD_W];
  endfunction

  function automatic logic [FIELD_W-1:0] f_rs2(input entry_t e);
    return e.instr[RS2_LSB +: FIELD_W];
  endfunction

  // True when younger may not pass older: RAW, WAR or WAW on a non-zero register.
  function automatic logic hazard(input entry_t older, input entry_t younger);
    logic o_wr;
    logic y_wr;
    logic raw;
    logic war;
    logic waw;
    o_wr = older.regwrite && (f_rd(older) != '0);
    y_wr = younger.regwrite && (f_rd(younger) != '0);
    raw  = o_wr && ((f_rs1(younger) == f_rd(older)) ||
                    (younger.rs2_used && (f_rs2(younger) == f_rd(older))));
    war  = y_wr && ((f_rs1(older) == f_rd(younger)) ||
                    (older.rs2_used && (f_rs2(older) == f_rd(younger))));
    waw  = o_wr && y_wr && (f_rd(older) == f_rd(younger));
    return raw || war || waw;
  endfunction

endpackage

// File: rtl/esm_scoreboard.sv
// Register busy scoreboard. Issue sets a bit, writeback clears it; a set and a
// clear of the same register in one cycle leaves it busy. Register 0 is never busy.
module esm_scoreboard
  import esm_pkg::*;
#(
  parameter  int REGNUM = 32,
  localparam int REG_W  = $clog2(REGNUM)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_set_valid,
  input  logic [FIELD_W-1:0] i_set_idx,
  input  logic               i_clr_valid,
  input  logic [REG_W-1:0]   i_clr_idx,
  output logic [REGNUM-1:0]  o_busy_q
);

  logic [REGNUM-1:0] r_busy;

  // Per-register set/clear with set priority; out-of-range indices match nothing.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= '0;
    end else begin
      r_busy[0] <= 1'b0;
      for (int r = 1; r < REGNUM; r++) begin
        if (i_set_valid && (i_set_idx == r[FIELD_W-1:0])) begin
          r_busy[r] <= 1'b1;
        end else if (i_clr_valid && (i_clr_idx == r[REG_W-1:0])) begin
          r_busy[r] <= 1'b0;
        end
      end
    end
  end

  assign o_busy_q = r_busy;

endmodule

// File: rtl/esm_issue_window.sv
// ESM issue window: fills DEPTH entries from fetch, then drains them one issue
// per cycle, either hazard-aware out of order or strictly in age order.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_FILL  | accepting instructions into slot[count]; nothing is issued
// ST_DRAIN | no accepts; presenting the selected entry until all have issued
module esm_issue_window
  import esm_pkg::*;
#(
  parameter  int INSTR_W       = 32,
  parameter  int DEPTH         = 16,
  parameter  int REGNUM        = 32,
  parameter  int OOO           = 1,
  parameter  int DRAIN_ON_IDLE = 1,
  localparam int IDX_W         = $clog2(DEPTH),
  localparam int REG_W         = $clog2(REGNUM)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [INSTR_W-1:0] i_in_instr,
  input  logic               i_in_regwrite,
  input  logic               i_in_alusrc,
  input  logic               i_in_last,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [INSTR_W-1:0] o_out_instr,
  output logic [IDX_W-1:0]   o_out_idx,
  input  logic               i_wb_valid,
  input  logic [REG_W-1:0]   i_wb_rd,
  output logic [REGNUM-1:0]  o_busy_q,
  output logic               o_drain_done
);

  localparam int CNT_W = IDX_W + 1;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_count;
  entry_t                 r_win [DEPTH];

  logic                   w_accept;
  logic                   w_issue;
  logic                   w_last_issue;
  logic                   w_found;
  logic                   w_stop;
  logic [IDX_W-1:0]       w_sel;
  logic [DEPTH-1:0]       w_pend;
  logic [DEPTH-1:0]       w_ok;
  logic [DEPTH-1:0]       w_others;
  logic [REGNUM-1:0]      w_busy;
  logic [MAX_INSTR_W-1:0] w_sel_instr;

  function automatic logic reg_busy(input logic [REGNUM-1:0] busy,
                                    input logic [FIELD_W-1:0] idx);
    logic b;
    b = 1'b0;
    for (int r = 1; r < REGNUM; r++) begin
      if (idx == r[FIELD_W-1:0]) b = busy[r];
    end
    return b;
  endfunction

  assign o_in_ready = (r_state == ST_FILL) && (r_count < CNT_W'(DEPTH));
  assign w_accept   = i_in_valid && o_in_ready;

  // Per-entry pending flag and eligibility against the scoreboard and older entries.
  always_comb begin
    w_pend = '0;
    w_ok   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_pend[i] = r_win[i].valid && !r_win[i].issued;
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_ok[i] = !reg_busy(w_busy, f_rs1(r_win[i])) &&
                !(r_win[i].rs2_used && reg_busy(w_busy, f_rs2(r_win[i]))) &&
                !(r_win[i].regwrite && reg_busy(w_busy, f_rd(r_win[i])));
      if (OOO != 0) begin
        for (int j = 0; j < i; j++) begin
          if (w_pend[j] && hazard(r_win[j], r_win[i])) w_ok[i] = 1'b0;
        end
      end
    end
  end

  // Pick the lowest eligible slot; in-order mode never looks past the oldest pending one.
  always_comb begin
    w_found = 1'b0;
    w_stop  = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_found && !w_stop && w_pend[i]) begin
        if (w_ok[i]) begin
          w_found = 1'b1;
          w_sel   = IDX_W'(i);
        end else if (OOO == 0) begin
          w_stop = 1'b1;
        end
      end
    end
    w_others        = w_pend;
    w_others[w_sel] = 1'b0;
  end

  assign w_sel_instr  = r_win[w_sel].instr;
  assign o_out_instr  = w_sel_instr[INSTR_W-1:0];
  assign o_out_idx    = w_sel;
  assign o_out_valid  = (r_state == ST_DRAIN) && w_found;
  assign w_issue      = o_out_valid && i_out_ready;
  assign w_last_issue = w_issue && (w_others == '0);
  assign o_drain_done = w_last_issue;

  generate
    if (INSTR_W < MAX_INSTR_W) begin : g_pad
      logic w_unused_pad;
      assign w_unused_pad = ^w_sel_instr[MAX_INSTR_W-1:INSTR_W];
    end
  endgenerate

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_FILL;
    else       r_state <= w_state_nxt;
  end

  // Next state: leave FILL on full, last, or idle input; leave DRAIN on the final issue.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL: begin
        if (w_accept && ((r_count == CNT_W'(DEPTH - 1)) || i_in_last)) begin
          w_state_nxt = ST_DRAIN;
        end else if ((DRAIN_ON_IDLE != 0) && !i_in_valid && (r_count != '0)) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_last_issue) w_state_nxt = ST_FILL;
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  // Window storage: write on accept, mark issued on handshake, wipe after the last issue.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_win[i] <= '0;
    end else if (r_state == ST_FILL) begin
      if (w_accept) begin
        r_win[r_count[IDX_W-1:0]] <= '{instr:    MAX_INSTR_W'(i_in_instr),
                                       regwrite: i_in_regwrite,
                                       rs2_used: !i_in_alusrc,
                                       valid:    1'b1,
                                       issued:   1'b0};
        r_count <= r_count + CNT_W'(1);
      end
    end else begin
      if (w_last_issue) begin
        r_count <= '0;
        for (int i = 0; i < DEPTH; i++) r_win[i] <= '0;
      end else if (w_issue) begin
        r_win[w_sel].issued <= 1'b1;
      end
    end
  end

  esm_scoreboard #(
    .REGNUM (REGNUM)
  ) u_scoreboard (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_set_valid (w_issue && r_win[w_sel].regwrite),
    .i_set_idx   (r_win[w_sel].instr[RD_LSB +: FIELD_W]),
    .i_clr_valid (i_wb_valid),
    .i_clr_idx   (i_wb_rd),
    .o_busy_q    (w_busy)
  );

  assign o_busy_q = w_busy;

endmodule

// File: tb/tb_esm_issue_window.sv
// Bench for esm_issue_window: an out-of-order and an in-order instance share
// one directed stimulus; a register-mask model predicts both every cycle.
module tb_esm_issue_window;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_regwrite, in_alusrc, in_last;
  logic [31:0] in_instr;
  logic        out_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;

  logic        s_rdy  [2];
  logic        s_val  [2];
  logic        s_done [2];
  logic [3:0]  s_idx  [2];
  logic [31:0] s_ins  [2];
  logic [31:0] s_busy [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  esm_issue_window #(.INSTR_W(32), .DEPTH(16), .REGNUM(32), .OOO(1), .DRAIN_ON_IDLE(1)) dut_ooo (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(s_rdy[0]),
    .i_in_instr(in_instr), .i_in_regwrite(in_regwrite), .i_in_alusrc(in_alusrc),
    .i_in_last(in_last), .o_out_valid(s_val[0]), .i_out_ready(out_ready),
    .o_out_instr(s_ins[0]), .o_out_idx(s_idx[0]), .i_wb_valid(wb_valid),
    .i_wb_rd(wb_rd), .o_busy_q(s_busy[0]), .o_drain_done(s_done[0]));

  esm_issue_window #(.INSTR_W(32), .DEPTH(16), .REGNUM(32), .OOO(0), .DRAIN_ON_IDLE(1)) dut_ino (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(s_rdy[1]),
    .i_in_instr(in_instr), .i_in_regwrite(in_regwrite), .i_in_alusrc(in_alusrc),
    .i_in_last(in_last), .o_out_valid(s_val[1]), .i_out_ready(out_ready),
    .o_out_instr(s_ins[1]), .o_out_idx(s_idx[1]), .i_wb_valid(wb_valid),
    .i_wb_rd(wb_rd), .o_busy_q(s_busy[1]), .o_drain_done(s_done[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b0, rd, 7'h33};
  endfunction

  function automatic bit [31:0] bitm(input logic [4:0] r);
    return (r == 5'd0) ? 32'h0 : (32'h1 << r);
  endfunction

  // Model: per instance, entries as read/write register masks plus a busy mask.
  bit          m_drain [2];
  int          m_n     [2];
  bit [31:0]   m_busy  [2];
  bit [31:0]   m_ins   [2][16];
  bit [31:0]   m_rm    [2][16];
  bit [31:0]   m_wm    [2][16];
  bit          m_done  [2][16];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin : per_inst
      int sel;
      int rem;
      bit ok;
      bit stop;
      bit ev;
      sel  = -1;
      rem  = 0;
      stop = 1'b0;
      if (m_drain[k]) begin
        for (int i = 0; i < m_n[k]; i++) if (!m_done[k][i]) rem++;
        for (int i = 0; i < m_n[k]; i++) begin
          if (!m_done[k][i] && sel < 0 && !stop) begin
            ok = (((m_rm[k][i] | m_wm[k][i]) & m_busy[k]) == 32'h0);
            if (k == 0) begin
              for (int j = 0; j < i; j++) begin
                if (!m_done[k][j] &&
                    (((m_wm[k][j] & (m_rm[k][i] | m_wm[k][i])) | (m_rm[k][j] & m_wm[k][i])) != 32'h0))
                  ok = 1'b0;
              end
            end
            if (ok) sel = i;
            else if (k == 1) stop = 1'b1;
          end
        end
      end
      ev = (sel >= 0);
      chk($sformatf("m%0d_in_ready", k), s_rdy[k], !m_drain[k] && (m_n[k] < 16));
      chk($sformatf("m%0d_out_valid", k), s_val[k], ev);
      chk($sformatf("m%0d_drain_done", k), s_done[k], ev && out_ready && (rem == 1));
      chk($sformatf("m%0d_busy_q", k), s_busy[k], m_busy[k]);
      if (ev) begin
        chk($sformatf("m%0d_out_idx", k), s_idx[k], sel);
        chk($sformatf("m%0d_out_instr", k), s_ins[k], m_ins[k][sel]);
      end
      if (rst) begin
        m_drain[k] = 1'b0;
        m_n[k]     = 0;
        m_busy[k]  = 32'h0;
        for (int i = 0; i < 16; i++) m_done[k][i] = 1'b0;
      end else begin
        if (wb_valid) m_busy[k] &= ~bitm(wb_rd);
        if (m_drain[k]) begin
          if (ev && out_ready) begin
            m_done[k][sel] = 1'b1;
            m_busy[k] |= m_wm[k][sel];
            if (rem == 1) begin
              m_drain[k] = 1'b0;
              m_n[k]     = 0;
              for (int i = 0; i < 16; i++) m_done[k][i] = 1'b0;
            end
          end
        end else if (in_valid && m_n[k] < 16) begin
          m_ins[k][m_n[k]]  = in_instr;
          m_rm[k][m_n[k]]   = bitm(in_instr[19:15]) | (in_alusrc ? 32'h0 : bitm(in_instr[24:20]));
          m_wm[k][m_n[k]]   = in_regwrite ? bitm(in_instr[11:7]) : 32'h0;
          m_done[k][m_n[k]] = 1'b0;
          m_n[k]++;
          if (m_n[k] == 16 || in_last) m_drain[k] = 1'b1;
        end else if (!in_valid && m_n[k] > 0) begin
          m_drain[k] = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] ins, input logic wr, input logic alu, input logic last);
    in_valid    = 1'b1;
    in_instr    = ins;
    in_regwrite = wr;
    in_alusrc   = alu;
    in_last     = last;
    tick();
  endtask

  task automatic see(input int k, input string name, input logic v, input logic [3:0] idx, input logic d);
    chk($sformatf("%s_valid%0d", name, k), s_val[k], v);
    if (v) chk($sformatf("%s_idx%0d", name, k), s_idx[k], idx);
    chk($sformatf("%s_done%0d", name, k), s_done[k], d);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_regwrite = 1'b0; in_alusrc = 1'b0; in_last = 1'b0;
    in_instr = 32'h0; out_ready = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", s_rdy[0], 1'b1);
    chk("rst_out_valid", s_val[0], 1'b0);
    chk("rst_busy", s_busy[0], 32'h0);
    chk("rst_done", s_done[0], 1'b0);

    // Three independent writers, in_last on the third.
    out_ready = 1'b1;
    push(mk(1, 0, 0), 1, 0, 0);
    push(mk(2, 0, 0), 1, 0, 0);
    push(mk(3, 0, 0), 1, 0, 1);
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk); see(0, "t1c1", 1, 0, 0); see(1, "t1c1", 1, 0, 0);
    chk("t1_in_ready", s_rdy[0], 1'b0);
    tick();
    @(negedge clk); see(0, "t1c2", 1, 1, 0);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd3;
    @(negedge clk); see(0, "t1c3", 1, 2, 1); see(1, "t1c3", 1, 2, 1);
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    chk("t1_busy", s_busy[0], 32'h0000_000E);
    chk("t1_back_fill", s_rdy[0], 1'b1);
    wb_valid = 1'b1;
    for (int r = 0; r < 4; r++) begin
      wb_rd = 5'(r);
      tick();
    end
    wb_valid = 1'b0;

    // r5 made busy, then a dependent and an independent instruction.
    push(mk(5, 0, 0), 1, 0, 1);
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    push(mk(6, 5, 0), 1, 0, 0);
    push(mk(7, 1, 2), 1, 0, 1);
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk); see(0, "t2c1", 1, 1, 0); see(1, "t2c1", 0, 0, 0);
    tick();
    @(negedge clk); see(0, "t2c2", 0, 0, 0); see(1, "t2c2", 0, 0, 0);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd5;
    @(negedge clk); see(0, "t2wb", 0, 0, 0); see(1, "t2wb", 0, 0, 0);
    tick();
    wb_valid = 1'b0;
    @(negedge clk); see(0, "t2c4", 1, 0, 1); see(1, "t2c4", 1, 0, 0);
    tick();
    @(negedge clk); see(1, "t2c5", 1, 1, 1);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd6; tick();
    wb_rd = 5'd7; tick();
    wb_valid = 1'b0;

    // Fill all 16 slots without in_last; a 17th word is held off.
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(mk(5'(i), 0, 0), 0, 1, 0);
    in_instr = mk(31, 0, 0);
    @(negedge clk);
    chk("f16_in_ready0", s_rdy[0], 1'b0);
    chk("f16_in_ready1", s_rdy[1], 1'b0);
    see(0, "f16", 1, 0, 0);
    tick();
    @(negedge clk); chk("f16_held", s_rdy[0], 1'b0);
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (16) tick();
    @(negedge clk);
    chk("f16_refill0", s_rdy[0], 1'b1);
    chk("f16_refill1", s_rdy[1], 1'b1);

    // WAR and WAW ordering.
    push(mk(1, 2, 0), 1, 0, 0);
    push(mk(2, 3, 0), 1, 0, 0);
    push(mk(1, 4, 0), 1, 0, 1);
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk); see(0, "w1", 1, 0, 0);
    tick();
    @(negedge clk); see(0, "w2", 1, 1, 0);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd1;
    @(negedge clk); see(0, "w3", 0, 0, 0);
    tick();
    wb_valid = 1'b0;
    @(negedge clk); see(0, "w4", 1, 2, 1); see(1, "w4", 1, 2, 1);
    tick();
    @(negedge clk);
    chk("w_busy0", s_busy[0], 32'h0000_0006);
    chk("w_busy1", s_busy[1], 32'h0000_0006);

    // Idle-triggered drain, one issue, then reset mid-drain.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(mk(5'(8 + i), 0, 0), 1, 0, 0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("r_fill_ready", s_rdy[0], 1'b1);
    chk("r_fill_valid", s_val[0], 1'b0);
    tick();
    @(negedge clk); see(0, "r_d1", 1, 0, 0);
    chk("r_d1_ready", s_rdy[0], 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; rst = 1'b1;
    @(negedge clk); chk("r_busy_pre", s_busy[0], 32'h0000_0106);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("r_in_ready", s_rdy[0], 1'b1);
    chk("r_out_valid", s_val[0], 1'b0);
    chk("r_busy", s_busy[0], 32'h0);
    chk("r_busy1", s_busy[1], 32'h0);
    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
